wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Consumer end of the MEM/WB pipeline register: selects the writeback value (memory data vs ALU
//  result), commits it to a 32-entry architectural register file, serves the two ID-stage read ports.
//  Also keeps a retired-instruction counter and a one-cycle "last commit" record for debug/forwarding.
//  Sits between the MEM/WB register outputs and the ID stage / hazard logic.
// PARAMETERS
//  XLEN        32  data width of registers, MD_i, ALUout_i
//  NREGS       32  architectural register count (x0 hardwired zero)
//  CNT_W       64  width of the retired-instruction counter
// PORTS
//  clk_i        in   1      clock, all state updates on rising edge
//  rst_i        in   1      reset, asynchronous, active-high
//  wb_valid_i   in   1      MEM/WB slot holds a real instruction (0 = bubble)
//  RegWrite_i   in   1      instruction writes a register
//  MemtoReg_i   in   1      1: write MD_i, 0: write ALUout_i
//  MD_i         in   XLEN   memory load data from MEM/WB
//  ALUout_i     in   XLEN   ALU result from MEM/WB
//  RD_i         in   5      destination register index
//  RS1addr_i    in   5      read port 1 address (ID stage)
//  RS2addr_i    in   5      read port 2 address (ID stage)
//  RS1data_o    out  XLEN   read port 1 data (combinational from array, see bypass)
//  RS2data_o    out  XLEN   read port 2 data
//  WBdata_o     out  XLEN   selected writeback value, combinational, for EX forwarding
//  last_vld_o   out  1      registered: a register commit happened last cycle
//  last_rd_o    out  5      registered: index committed last cycle
//  last_data_o  out  XLEN   registered: value committed last cycle
//  instret_o    out  CNT_W  registered: count of retired (wb_valid_i=1) instructions
// BEHAVIOUR
//  - WBdata_o = MemtoReg_i ? MD_i : ALUout_i, independent of valid.
//  - commit = wb_valid_i & RegWrite_i & (RD_i != 0); on commit, regs[RD_i] <= WBdata_o at posedge.
//  - x0: never written, always reads 0 on both ports regardless of bypass or pending writes.
//  - Reads asynchronous: RSn_data_o = regs[RSn_addr_i] (subject to WB_BYPASS_EN below).
//  - last_vld_o <= commit; last_rd_o/last_data_o load only when commit, hold otherwise.
//  - instret_o increments by 1 each cycle wb_valid_i=1 (independent of RegWrite_i); wraps
//    all-ones -> 0 silently.
//  - rst_i asserted (any time, incl. mid-stream): all regs[1..31]=0, last_vld_o=0, last_rd_o=0,
//    last_data_o=0, instret_o=0 immediately; no commit occurs on an edge where rst_i is high.
//  - Both read ports may address the same register; simultaneous read of RD_i during commit
//    follows WB_BYPASS_EN rule. Latency: write visible to array reads 1 cycle after commit edge.
//  - No internal FSM; state = array, counter, last-commit record.
// CONFIGURATION
//  WB_BYPASS_EN defined: if commit and RSn_addr_i == RD_i (nonzero), RSn_data_o = WBdata_o in
//    the same cycle (write-before-read); hazard unit need not stall/forward from WB.
//  WB_BYPASS_EN undefined: RSn_data_o always returns the pre-commit array value; hazard/forwarding
//    logic must cover the WB->ID case.
// STRUCTURE
//  - Shared package: XLEN, REG_ADDR_W=5, REG_ZERO=5'd0, CNT_W defaults.
//  - One sub-module: wb_regfile_array (NREGS x XLEN storage, 1 write port, 2 async read ports,
//    async reset); writeback mux, bypass, counter and last-commit record stay in wb_regfile.
// TESTING
//  1 reset: pulse rst_i mid-run after writes -> all reads 0, instret_o=0, last_vld_o=0 same cycle.
//  2 ALU path: valid,RegWrite,MemtoReg=0,ALUout=32'hDEADBEEF,RD=5 -> next cycle RS1addr=5 reads
//    DEADBEEF, last_rd_o=5, last_vld_o=1, instret_o=1.
//  3 load path + x0: MemtoReg=1,MD=32'h1234,RD=0 -> no write, RS1addr=0 reads 0, last_vld_o=0,
//    instret_o increments.
//  4 bubble: wb_valid_i=0,RegWrite=1,RD=7,ALUout=9 -> x7 unchanged, instret_o unchanged.
//  5 bypass: commit RD=3 data 32'hA5A5 while RS1addr=RS2addr=3 -> same cycle both read A5A5
//    with WB_BYPASS_EN, old x3 value without.
//  6 wrap: force instret to all-ones, one valid -> instret_o=0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared widths and helpers for the writeback / register-file slice.
package wb_regfile_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W_DEF  = 64;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // x0 is hardwired, so a writeback aimed at it is never a commit.
  function automatic logic is_commit(input logic valid, input logic reg_write,
                                     input logic [REG_ADDR_W-1:0] rd);
    return valid & reg_write & (rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB -> writeback bus plus ID-stage read ports and last-commit record.
interface wb_regfile_if
  import wb_regfile_pkg::*;
();

  logic                  wb_valid_i;
  logic                  RegWrite_i;
  logic                  MemtoReg_i;
  logic [XLEN-1:0]       MD_i;
  logic [XLEN-1:0]       ALUout_i;
  logic [REG_ADDR_W-1:0] RD_i;
  logic [REG_ADDR_W-1:0] RS1addr_i;
  logic [REG_ADDR_W-1:0] RS2addr_i;
  logic [XLEN-1:0]       RS1data_o;
  logic [XLEN-1:0]       RS2data_o;
  logic [XLEN-1:0]       WBdata_o;
  logic                  last_vld_o;
  logic [REG_ADDR_W-1:0] last_rd_o;
  logic [XLEN-1:0]       last_data_o;

  modport master (
    output wb_valid_i, RegWrite_i, MemtoReg_i, MD_i, ALUout_i, RD_i, RS1addr_i, RS2addr_i,
    input  RS1data_o, RS2data_o, WBdata_o, last_vld_o, last_rd_o, last_data_o
  );

  modport slave (
    input  wb_valid_i, RegWrite_i, MemtoReg_i, MD_i, ALUout_i, RD_i, RS1addr_i, RS2addr_i,
    output RS1data_o, RS2data_o, WBdata_o, last_vld_o, last_rd_o, last_data_o
  );

endinterface

// File: rtl/wb_regfile_array.sv
// NREGS x XLEN register storage: one write port, two asynchronous read ports, x0 reads zero.
module wb_regfile_array
  import wb_regfile_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_we,
  input  logic [REG_ADDR_W-1:0] i_waddr,
  input  logic [XLEN-1:0]       i_wdata,
  input  logic [REG_ADDR_W-1:0] i_raddr1,
  input  logic [REG_ADDR_W-1:0] i_raddr2,
  output logic [XLEN-1:0]       o_rdata1,
  output logic [XLEN-1:0]       o_rdata2
);

  logic [XLEN-1:0] r_regs [NREGS];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_regs[gi] <= '0;
        end else if (i_we && (i_waddr == REG_ADDR_W'(gi)) && (gi != 0)) begin
          r_regs[gi] <= i_wdata;
        end
      end
    end
  endgenerate

  assign o_rdata1 = (i_raddr1 == REG_ZERO) ? '0 : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == REG_ZERO) ? '0 : r_regs[i_raddr2];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result select, register-file commit, retired counter, last-commit record.
// Optional same-cycle write-to-read bypass is enabled by defining WB_BYPASS_EN.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  wb_regfile_if.slave      bus,
  output logic [CNT_W-1:0] instret_o
);

  logic [XLEN-1:0]       w_wbdata;
  logic                  w_commit;
  logic [XLEN-1:0]       w_arr_rs1;
  logic [XLEN-1:0]       w_arr_rs2;
  logic [XLEN-1:0]       w_rs1;
  logic [XLEN-1:0]       w_rs2;

  logic                  r_last_vld;
  logic [REG_ADDR_W-1:0] r_last_rd;
  logic [XLEN-1:0]       r_last_data;
  logic [CNT_W-1:0]      r_instret;

  assign w_wbdata = bus.MemtoReg_i ? bus.MD_i : bus.ALUout_i;
  // Gated by reset so neither the array nor the bypass sees a commit while in reset.
  assign w_commit = is_commit(bus.wb_valid_i, bus.RegWrite_i, bus.RD_i) & ~rst_i;

  wb_regfile_array u_array (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_we     (w_commit),
    .i_waddr  (bus.RD_i),
    .i_wdata  (w_wbdata),
    .i_raddr1 (bus.RS1addr_i),
    .i_raddr2 (bus.RS2addr_i),
    .o_rdata1 (w_arr_rs1),
    .o_rdata2 (w_arr_rs2)
  );

`ifdef WB_BYPASS_EN
  assign w_rs1 = (w_commit && (bus.RS1addr_i == bus.RD_i)) ? w_wbdata : w_arr_rs1;
  assign w_rs2 = (w_commit && (bus.RS2addr_i == bus.RD_i)) ? w_wbdata : w_arr_rs2;
`else
  assign w_rs1 = w_arr_rs1;
  assign w_rs2 = w_arr_rs2;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_vld  <= 1'b0;
      r_last_rd   <= '0;
      r_last_data <= '0;
      r_instret   <= '0;
    end else begin
      r_last_vld <= w_commit;
      if (w_commit) begin
        r_last_rd   <= bus.RD_i;
        r_last_data <= w_wbdata;
      end
      if (bus.wb_valid_i) begin
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  assign bus.RS1data_o   = w_rs1;
  assign bus.RS2data_o   = w_rs2;
  assign bus.WBdata_o    = w_wbdata;
  assign bus.last_vld_o  = r_last_vld;
  assign bus.last_rd_o   = r_last_rd;
  assign bus.last_data_o = r_last_data;
  assign instret_o       = r_instret;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expectations, a negedge monitor checks them.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef enum int {K_RS1, K_RS2, K_WB, K_LVLD, K_LRD, K_LDATA, K_INS, K_INSW} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    logic [63:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CNT_W_DEF-1:0] instret;
  logic [3:0]           instret_w;

  exp_t exp_q [$];
  exp_t cur;
  int total = 0;
  int bad   = 0;

  wb_regfile_if u_if   ();
  wb_regfile_if u_if_w ();

  wb_regfile u_dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (u_if),
    .instret_o (instret)
  );

  // Narrow-counter instance so the wrap-around is reachable in a few cycles.
  wb_regfile #(.CNT_W(4)) u_dut_w (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (u_if_w),
    .instret_o (instret_w)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] actual(input kind_e k);
    case (k)
      K_RS1:   return {32'b0, u_if.RS1data_o};
      K_RS2:   return {32'b0, u_if.RS2data_o};
      K_WB:    return {32'b0, u_if.WBdata_o};
      K_LVLD:  return {63'b0, u_if.last_vld_o};
      K_LRD:   return {59'b0, u_if.last_rd_o};
      K_LDATA: return {32'b0, u_if.last_data_o};
      K_INS:   return instret;
      K_INSW:  return {60'b0, instret_w};
      default: return '1;
    endcase
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      total++;
      if (actual(cur.kind) !== cur.val) begin
        bad++;
        $display("FAIL %s: got %h want %h", cur.name, actual(cur.kind), cur.val);
      end else begin
        $display("ok   %s = %h", cur.name, cur.val);
      end
    end
  end

  task automatic expect_val(input string n, input kind_e k, input logic [63:0] v);
    exp_t e;
    e.name = n;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r,
                       input logic [31:0] md, input logic [31:0] alu,
                       input logic [4:0] rd, input logic [4:0] a1, input logic [4:0] a2);
    u_if.wb_valid_i = v;
    u_if.RegWrite_i = rw;
    u_if.MemtoReg_i = m2r;
    u_if.MD_i       = md;
    u_if.ALUout_i   = alu;
    u_if.RD_i       = rd;
    u_if.RS1addr_i  = a1;
    u_if.RS2addr_i  = a2;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 5, 0);
    u_if_w.wb_valid_i = 0;
    u_if_w.RegWrite_i = 0;
    u_if_w.MemtoReg_i = 0;
    u_if_w.MD_i       = 0;
    u_if_w.ALUout_i   = 0;
    u_if_w.RD_i       = 0;
    u_if_w.RS1addr_i  = 0;
    u_if_w.RS2addr_i  = 0;
    rst = 1'b1;

    step();
    expect_val("rst_instret", K_INS, 0);
    expect_val("rst_lvld", K_LVLD, 0);
    expect_val("rst_rs1", K_RS1, 0);
    step();
    rst = 1'b0;

    // ALU writeback to x5
    step();
    drive(1, 1, 0, 32'h55, 32'hDEADBEEF, 5, 5, 0);
    expect_val("alu_wbdata", K_WB, 64'hDEADBEEF);
    expect_val("alu_rs1_same_cycle", K_RS1, BYP ? 64'hDEADBEEF : 64'h0);
    expect_val("alu_rs2_x0", K_RS2, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 5, 0);
    expect_val("alu_rs1_next", K_RS1, 64'hDEADBEEF);
    expect_val("alu_lvld", K_LVLD, 1);
    expect_val("alu_lrd", K_LRD, 5);
    expect_val("alu_ldata", K_LDATA, 64'hDEADBEEF);
    expect_val("alu_instret", K_INS, 1);

    // load path aimed at x0
    step();
    drive(1, 1, 1, 32'h1234, 32'h77, 0, 0, 5);
    expect_val("ld_wbdata", K_WB, 64'h1234);
    expect_val("ld_rs1_x0", K_RS1, 0);
    expect_val("ld_rs2_x5", K_RS2, 64'hDEADBEEF);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_val("x0_lvld", K_LVLD, 0);
    expect_val("x0_lrd_hold", K_LRD, 5);
    expect_val("x0_ldata_hold", K_LDATA, 64'hDEADBEEF);
    expect_val("x0_instret", K_INS, 2);
    expect_val("x0_rs1", K_RS1, 0);

    // bubble with RegWrite set
    step();
    drive(0, 1, 0, 0, 9, 7, 7, 0);
    expect_val("bub_wbdata", K_WB, 9);
    expect_val("bub_rs1", K_RS1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 7, 0);
    expect_val("bub_x7", K_RS1, 0);
    expect_val("bub_instret", K_INS, 2);
    expect_val("bub_lvld", K_LVLD, 0);

    // x3 = 1111, then overwrite with A5A5 while both ports read x3
    step();
    drive(1, 1, 0, 0, 32'h1111, 3, 3, 3);
    step();
    drive(1, 1, 0, 0, 32'hA5A5, 3, 3, 3);
    expect_val("byp_rs1", K_RS1, BYP ? 64'hA5A5 : 64'h1111);
    expect_val("byp_rs2", K_RS2, BYP ? 64'hA5A5 : 64'h1111);
    expect_val("byp_instret", K_INS, 3);
    step();
    drive(1, 1, 0, 0, 32'h42, 9, 3, 3);
    expect_val("post_rs1", K_RS1, 64'hA5A5);
    expect_val("post_rs2", K_RS2, 64'hA5A5);
    expect_val("post_lvld", K_LVLD, 1);
    expect_val("post_lrd", K_LRD, 3);
    expect_val("post_ldata", K_LDATA, 64'hA5A5);
    expect_val("post_instret", K_INS, 4);
    step();
    drive(0, 0, 0, 0, 0, 0, 9, 3);
    expect_val("x9_rs1", K_RS1, 64'h42);
    expect_val("x9_lrd", K_LRD, 9);
    expect_val("x9_ldata", K_LDATA, 64'h42);
    expect_val("x9_instret", K_INS, 5);

    // mid-stream reset with a pending commit to x10
    step();
    drive(1, 1, 0, 0, 32'hBAD, 10, 9, 3);
    rst = 1'b1;
    expect_val("mrst_rs1", K_RS1, 0);
    expect_val("mrst_rs2", K_RS2, 0);
    expect_val("mrst_instret", K_INS, 0);
    expect_val("mrst_lvld", K_LVLD, 0);
    expect_val("mrst_lrd", K_LRD, 0);
    expect_val("mrst_ldata", K_LDATA, 0);
    step();
    expect_val("mrst_hold_instret", K_INS, 0);
    expect_val("mrst_hold_lvld", K_LVLD, 0);
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 10, 0);
    expect_val("mrst_x10_unwritten", K_RS1, 0);
    expect_val("mrst_after_lvld", K_LVLD, 0);
    expect_val("mrst_after_instret", K_INS, 0);

    // counter wrap on the 4-bit instance
    u_if_w.wb_valid_i = 1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 15) expect_val("wrap_all_ones", K_INSW, 64'hF);
      if (i == 16) begin
        expect_val("wrap_zero", K_INSW, 0);
        u_if_w.wb_valid_i = 0;
      end
    end

    step();
    step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
